// File: rtl/sip_pkg.sv
// Shared definitions for the SipHash message controller: initialisation
// constants, the finalisation XOR byte, the controller state encoding and a
// byte-masking helper.
package sip_pkg;

    localparam logic [63:0] IV0 = 64'h736f6d6570736575;
    localparam logic [63:0] IV1 = 64'h646f72616e646f6d;
    localparam logic [63:0] IV2 = 64'h6c7967656e657261;
    localparam logic [63:0] IV3 = 64'h7465646279746573;

    localparam logic [7:0] FINAL_XOR = 8'hff;

    typedef enum logic [2:0] {
        IDLE,
        ABSORB,
        PAD,
        COMP,
        FINAL,
        DONE
    } sip_state_t;

    // Keep only the low nbytes bytes of a little-endian word; the rest read as zero.
    function automatic logic [63:0] mask_bytes(input logic [63:0] data, input logic [3:0] nbytes);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            if (4'(i) < nbytes) begin
                r[8*i +: 8] = data[8*i +: 8];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sip_round.sv
// One SipRound of the SipHash ARX permutation, registered at the output.
// The state presented on iv0..iv3 is captured at the clock edge and the
// permuted state appears on ov0..ov3 during the following cycle.
module sip_round (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] iv0,
    input  logic [63:0] iv1,
    input  logic [63:0] iv2,
    input  logic [63:0] iv3,
    output logic [63:0] ov0,
    output logic [63:0] ov1,
    output logic [63:0] ov2,
    output logic [63:0] ov3
);

    logic [63:0] a, b, c, d;

    function automatic logic [63:0] rotl(input logic [63:0] x, input int r);
        return (x << r) | (x >> (64 - r));
    endfunction

    // Combinational add-rotate-xor network of a single round.
    always_comb begin
        a = iv0 + iv1;
        b = rotl(iv1, 13) ^ a;
        a = rotl(a, 32);
        c = iv2 + iv3;
        d = rotl(iv3, 16) ^ c;
        a = a + d;
        d = rotl(d, 21) ^ a;
        c = c + b;
        b = rotl(b, 17) ^ c;
        c = rotl(c, 32);
    end

    // Pipeline register holding the round result for the next cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ov0 <= '0;
            ov1 <= '0;
            ov2 <= '0;
            ov3 <= '0;
        end else begin
            ov0 <= a;
            ov1 <= b;
            ov2 <= c;
            ov3 <= d;
        end
    end

endmodule

// File: rtl/sip_hash_ctrl.sv
// SipHash-c-d message controller. Loads the key, absorbs little-endian
// 64-bit words, appends the length block, runs compression and finalisation
// rounds through a single pipelined sip_round and returns the 64-bit tag.
// Optional feature: define SIP_ABORT_EN to add an 'abort' input that cancels
// the current hash from any state.
module sip_hash_ctrl
    import sip_pkg::*;
#(
    parameter int C_ROUNDS = 2,
    parameter int D_ROUNDS = 4
) (
    input  logic         clk,
    input  logic         rst_n,
`ifdef SIP_ABORT_EN
    input  logic         abort,
`endif
    input  logic [127:0] key,
    input  logic         start,
    input  logic         msg_valid,
    output logic         msg_ready,
    input  logic [63:0]  msg_data,
    input  logic [3:0]   msg_bytes,
    input  logic         msg_last,
    output logic         hash_valid,
    input  logic         hash_ready,
    output logic [63:0]  hash,
    output logic         busy
);

    localparam logic [7:0] C_LAST = 8'(C_ROUNDS);
    localparam logic [7:0] D_LAST = 8'(D_ROUNDS);

    sip_state_t  state;
    logic [7:0]  k;
    logic [63:0] v0, v1, v2, v3;
    logic [63:0] m;
    logic [7:0]  len;
    logic        last_seen;
    logic        pad_pending;
    logic [63:0] iv0, iv1, iv2, iv3;
    logic [63:0] ov0, ov1, ov2, ov3;
    logic [7:0]  len_new;
    logic [63:0] data_masked;
    logic        abort_hit;

`ifdef SIP_ABORT_EN
    assign abort_hit = abort;
`else
    assign abort_hit = 1'b0;
`endif

    assign len_new     = len + {4'b0000, msg_bytes};
    assign data_masked = mask_bytes(msg_data, msg_bytes);

    sip_round u_round (
        .clk   (clk),
        .rst_n (rst_n),
        .iv0   (iv0),
        .iv1   (iv1),
        .iv2   (iv2),
        .iv3   (iv3),
        .ov0   (ov0),
        .ov1   (ov1),
        .ov2   (ov2),
        .ov3   (ov3)
    );

    // Round input: fresh state on the first cycle of a pass, feedback afterwards.
    always_comb begin
        iv0 = ov0;
        iv1 = ov1;
        iv2 = ov2;
        iv3 = ov3;
        if (state == COMP && k == 8'd0) begin
            iv0 = v0;
            iv1 = v1;
            iv2 = v2;
            iv3 = v3 ^ m;
        end else if (state == FINAL && k == 8'd0) begin
            iv0 = v0;
            iv1 = v1;
            iv2 = v2 ^ {56'b0, FINAL_XOR};
            iv3 = v3;
        end
    end

    // Controller FSM with round counter and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            k           <= '0;
            v0          <= '0;
            v1          <= '0;
            v2          <= '0;
            v3          <= '0;
            m           <= '0;
            len         <= '0;
            last_seen   <= 1'b0;
            pad_pending <= 1'b0;
            msg_ready   <= 1'b0;
            hash_valid  <= 1'b0;
            hash        <= '0;
            busy        <= 1'b0;
        end else if (abort_hit) begin
            state       <= IDLE;
            k           <= '0;
            last_seen   <= 1'b0;
            pad_pending <= 1'b0;
            msg_ready   <= 1'b0;
            hash_valid  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        v0          <= key[63:0]   ^ IV0;
                        v1          <= key[127:64] ^ IV1;
                        v2          <= key[63:0]   ^ IV2;
                        v3          <= key[127:64] ^ IV3;
                        len         <= '0;
                        last_seen   <= 1'b0;
                        pad_pending <= 1'b0;
                        msg_ready   <= 1'b1;
                        busy        <= 1'b1;
                        state       <= ABSORB;
                    end
                end
                ABSORB: begin
                    if (msg_valid && (msg_bytes != 4'd0 || msg_last)) begin
                        len       <= len_new;
                        msg_ready <= 1'b0;
                        k         <= '0;
                        state     <= COMP;
                        if (!msg_last) begin
                            m <= data_masked;
                        end else if (msg_bytes < 4'd8) begin
                            m         <= data_masked | {len_new, 56'b0};
                            last_seen <= 1'b1;
                        end else begin
                            m           <= msg_data;
                            last_seen   <= 1'b1;
                            pad_pending <= 1'b1;
                        end
                    end
                end
                COMP: begin
                    if (k == C_LAST) begin
                        v0 <= ov0 ^ m;
                        v1 <= ov1;
                        v2 <= ov2;
                        v3 <= ov3;
                        k  <= '0;
                        if (pad_pending) begin
                            state <= PAD;
                        end else if (last_seen) begin
                            state <= FINAL;
                        end else begin
                            msg_ready <= 1'b1;
                            state     <= ABSORB;
                        end
                    end else begin
                        k <= k + 8'd1;
                    end
                end
                PAD: begin
                    m           <= {len, 56'b0};
                    pad_pending <= 1'b0;
                    k           <= '0;
                    state       <= COMP;
                end
                FINAL: begin
                    if (k == D_LAST) begin
                        hash       <= ov0 ^ ov1 ^ ov2 ^ ov3;
                        hash_valid <= 1'b1;
                        k          <= '0;
                        state      <= DONE;
                    end else begin
                        k <= k + 8'd1;
                    end
                end
                DONE: begin
                    if (hash_ready) begin
                        hash_valid <= 1'b0;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sip_hash_ctrl.sv
// Self-checking bench for sip_hash_ctrl: known SipHash-2-4 vectors from a
// table, randomised messages against a word-level reference model, and
// hand-written sequences for stall, reset and (with SIP_ABORT_EN) abort.
module tb_sip_hash_ctrl;

    localparam int C_R = 2;
    localparam int D_R = 4;
    localparam logic [127:0] KEY_STD = 128'h0f0e0d0c0b0a0908_0706050403020100;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [127:0] key = '0;
    logic         start = 1'b0;
    logic         msg_valid = 1'b0;
    logic         msg_ready;
    logic [63:0]  msg_data = '0;
    logic [3:0]   msg_bytes = '0;
    logic         msg_last = 1'b0;
    logic         hash_valid;
    logic         hash_ready = 1'b0;
    logic [63:0]  hash;
    logic         busy;
`ifdef SIP_ABORT_EN
    logic         abort = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [63:0] mw[64];
    logic [3:0]  mb[64];
    int          mn;
    int          acc_cyc[64];

    typedef struct {
        string        name;
        logic [127:0] key;
        int           n;
        logic [63:0]  w0;
        logic [3:0]   b0;
        logic [63:0]  w1;
        logic [3:0]   b1;
        logic [63:0]  exp;
    } vec_t;

    vec_t vecs[4];

    sip_hash_ctrl #(.C_ROUNDS(C_R), .D_ROUNDS(D_R)) dut (
`ifdef SIP_ABORT_EN
        .abort      (abort),
`endif
        .clk        (clk),
        .rst_n      (rst_n),
        .key        (key),
        .start      (start),
        .msg_valid  (msg_valid),
        .msg_ready  (msg_ready),
        .msg_data   (msg_data),
        .msg_bytes  (msg_bytes),
        .msg_last   (msg_last),
        .hash_valid (hash_valid),
        .hash_ready (hash_ready),
        .hash       (hash),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [63:0] rotl64(input logic [63:0] x, input int r);
        return (x << r) | (x >> (64 - r));
    endfunction

    function automatic logic [255:0] ref_round(input logic [255:0] s);
        logic [63:0] a, b, c, d;
        {a, b, c, d} = s;
        a = a + b; b = rotl64(b, 13); b = b ^ a; a = rotl64(a, 32);
        c = c + d; d = rotl64(d, 16); d = d ^ c;
        a = a + d; d = rotl64(d, 21); d = d ^ a;
        c = c + b; b = rotl64(b, 17); b = b ^ c; c = rotl64(c, 32);
        return {a, b, c, d};
    endfunction

    function automatic logic [63:0] ref_hash(input logic [127:0] k, input int n);
        logic [63:0]  blocks[$];
        logic [63:0]  d;
        logic [63:0]  a, b, c, e;
        logic [255:0] s;
        logic [7:0]   total_len;
        int           total;
        total = 0;
        for (int i = 0; i < n; i++) total += int'(mb[i]);
        total_len = 8'(total % 256);
        for (int i = 0; i < n; i++) begin
            d = '0;
            for (int j = 0; j < 8; j++) begin
                if (j < int'(mb[i])) d[8*j +: 8] = mw[i][8*j +: 8];
            end
            if (i < n - 1) begin
                if (mb[i] != 4'd0) blocks.push_back(d);
            end else if (mb[i] < 4'd8) begin
                blocks.push_back(d | {total_len, 56'b0});
            end else begin
                blocks.push_back(d);
                blocks.push_back({total_len, 56'b0});
            end
        end
        s = {k[63:0] ^ 64'h736f6d6570736575, k[127:64] ^ 64'h646f72616e646f6d,
             k[63:0] ^ 64'h6c7967656e657261, k[127:64] ^ 64'h7465646279746573};
        foreach (blocks[q]) begin
            s[63:0] = s[63:0] ^ blocks[q];
            for (int r = 0; r < C_R; r++) s = ref_round(s);
            s[255:192] = s[255:192] ^ blocks[q];
        end
        s[127:64] = s[127:64] ^ 64'hff;
        for (int r = 0; r < D_R; r++) s = ref_round(s);
        {a, b, c, e} = s;
        return a ^ b ^ c ^ e;
    endfunction

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic send_word(input int i, output logic ok);
        int cnt;
        msg_data  = mw[i];
        msg_bytes = mb[i];
        msg_last  = (i == mn - 1);
        msg_valid = 1'b1;
        cnt = 0;
        while (!msg_ready && cnt < 100) begin
            tick();
            cnt++;
        end
        ok = msg_ready;
        if (ok) begin
            tick();
            acc_cyc[i] = cyc;
        end
        msg_valid = 1'b0;
        msg_last  = 1'b0;
    endtask

    task automatic applyStimulus(input logic [127:0] k, input int gap_max, output logic ok);
        logic w_ok;
        key   = k;
        start = 1'b1;
        tick();
        start = 1'b0;
        ok = 1'b1;
        for (int i = 0; i < mn; i++) begin
            repeat ($urandom_range(0, gap_max)) tick();
            send_word(i, w_ok);
            if (!w_ok) begin
                ok = 1'b0;
                break;
            end
        end
    endtask

    task automatic wait_tag(output logic got);
        int cnt;
        cnt = 0;
        while (!hash_valid && cnt < 200) begin
            tick();
            cnt++;
        end
        got = hash_valid;
    endtask

    task automatic collect_tag(input string name, input logic [63:0] exp, input int ready_delay);
        logic got;
        wait_tag(got);
        if (!got) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s timeout hash_valid=0 expected tag=%h", name, exp);
            do_reset();
        end else begin
            checkOutput(name, hash, exp);
            repeat (ready_delay) tick();
            hash_ready = 1'b1;
            tick();
            hash_ready = 1'b0;
        end
    endtask

    task automatic run_message(input string name, input logic [127:0] k, input logic [63:0] exp,
                               input int gap_max, input int ready_delay);
        logic ok;
        applyStimulus(k, gap_max, ok);
        if (!ok) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s msg_ready timeout actual=0 expected=1", name);
            do_reset();
        end else begin
            collect_tag(name, exp, ready_delay);
        end
    endtask

    task automatic load_vec(input int v);
        mn    = vecs[v].n;
        mw[0] = vecs[v].w0;
        mb[0] = vecs[v].b0;
        mw[1] = vecs[v].w1;
        mb[1] = vecs[v].b1;
    endtask

    // ---------------- main sequence ----------------
    initial begin : main
        logic        ok;
        logic        got;
        logic [127:0] rk;
        logic [63:0] exp;
        int          bad;

        vecs[0] = '{"empty_msg",   KEY_STD, 1, 64'h0, 4'd0, 64'h0, 4'd0, 64'h726fdb47dd0e0e31};
        vecs[1] = '{"eight_bytes", KEY_STD, 1, 64'h0706050403020100, 4'd8, 64'h0, 4'd0, 64'h93f5f5799a932462};
        vecs[2] = '{"fifteen_bytes", KEY_STD, 2, 64'h0706050403020100, 4'd8,
                    64'h000e0d0c0b0a0908, 4'd7, 64'ha129ca6149be45e5};
        vecs[3] = '{"zero_word_discard", KEY_STD, 2, 64'hdeadbeefcafef00d, 4'd0,
                    64'h0706050403020100, 4'd8, 64'h93f5f5799a932462};

        // Reset state
        rst_n = 1'b0;
        repeat (3) tick();
        checkOutput("reset_msg_ready", 64'(msg_ready), 64'd0);
        checkOutput("reset_hash_valid", 64'(hash_valid), 64'd0);
        checkOutput("reset_hash", hash, 64'd0);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        tick();

        // Known-answer table
        for (int v = 0; v < 4; v++) begin
            load_vec(v);
            run_message(vecs[v].name, vecs[v].key, vecs[v].exp, 1, v);
        end

        // Stall on hash_ready, start pulses during DONE
        load_vec(0);
        applyStimulus(KEY_STD, 0, ok);
        checkOutput("stall_busy", 64'(busy), 64'd1);
        wait_tag(got);
        checkOutput("stall_got_tag", 64'(got), 64'd1);
        for (int t = 0; t < 10; t++) begin
            checkOutput("stall_valid", 64'(hash_valid), 64'd1);
            checkOutput("stall_hash", hash, vecs[0].exp);
            start = (t == 4);
            tick();
        end
        start = 1'b0;
        hash_ready = 1'b1;
        start = 1'b1;
        tick();
        hash_ready = 1'b0;
        checkOutput("done_start_ignored_busy", 64'(busy), 64'd0);
        checkOutput("done_release_valid", 64'(hash_valid), 64'd0);
        tick();
        start = 1'b0;
        checkOutput("start_after_done_busy", 64'(busy), 64'd1);
        checkOutput("start_after_done_ready", 64'(msg_ready), 64'd1);
        send_word(0, ok);
        collect_tag("restart_after_done", vecs[0].exp, 0);

        // Reset mid-COMP
        key   = KEY_STD;
        start = 1'b1;
        tick();
        start = 1'b0;
        mn    = 2;
        mw[0] = 64'h0706050403020100;
        mb[0] = 4'd8;
        send_word(0, ok);
        checkOutput("comp_ready_low", 64'(msg_ready), 64'd0);
        checkOutput("comp_busy", 64'(busy), 64'd1);
        tick();
        rst_n = 1'b0;
        tick();
        checkOutput("midreset_outputs", {hash[60:0], msg_ready, hash_valid, busy}, 64'd0);
        checkOutput("midreset_hash", hash, 64'd0);
        rst_n = 1'b1;
        tick();
        load_vec(0);
        run_message("after_reset_empty", KEY_STD, vecs[0].exp, 0, 0);

        // 300-byte message, msg_valid held high: length wraps, throughput checked
        rk = {$urandom, $urandom, $urandom, $urandom};
        mn = 38;
        for (int i = 0; i < 38; i++) begin
            mw[i] = {$urandom, $urandom};
            mb[i] = (i == 37) ? 4'd4 : 4'd8;
        end
        exp = ref_hash(rk, mn);
        applyStimulus(rk, 0, ok);
        checkOutput("long_msg_accepted", 64'(ok), 64'd1);
        bad = 0;
        for (int i = 1; i < 38; i++) begin
            if (acc_cyc[i] - acc_cyc[i-1] != C_R + 2) bad++;
        end
        checkOutput("throughput_bad_gaps", 64'(bad), 64'd0);
        if (ok) collect_tag("long_msg_300", exp, 2);
        else do_reset();

        // Randomised messages against the reference model
        for (int r = 0; r < 25; r++) begin
            rk = {$urandom, $urandom, $urandom, $urandom};
            mn = $urandom_range(1, 5);
            for (int i = 0; i < mn; i++) begin
                mw[i] = {$urandom, $urandom};
                mb[i] = 4'($urandom_range(0, 8));
            end
            exp = ref_hash(rk, mn);
            run_message($sformatf("random_%0d", r), rk, exp, 2, $urandom_range(0, 3));
        end

`ifdef SIP_ABORT_EN
        // Abort while absorbing
        key   = KEY_STD;
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("abort_pre_ready", 64'(msg_ready), 64'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkOutput("abort_ready", 64'(msg_ready), 64'd0);
        checkOutput("abort_busy", 64'(busy), 64'd0);
        load_vec(0);
        run_message("after_abort_empty", KEY_STD, vecs[0].exp, 0, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
